// File: rtl/cu_fsm_mc_pkg.sv
// Shared types for the Otter multicycle control FSM: state encoding and RV32I opcode/funct3 constants.
// Build option CU_MEM_TIMEOUT_EN, which bounds memory waits, is handled in cu_fsm_mc.sv.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } cu_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] FUNC3_CSRRW = 3'b001;
  localparam logic [2:0] FUNC3_MRET  = 3'b000;

endpackage

// File: rtl/cu_fsm_mc_if.sv
// Control bundle between the FSM (master: drives strobes) and datapath/memory (slave: drives decode, requests, ack).
// Signal names match the Otter datapath wiring; INT_ID width grows to encode the bus-error trap index NUM_INT.
interface cu_fsm_mc_if #(
  parameter int NUM_INT = 4
);
  localparam int INT_ID_W = $clog2(NUM_INT + 1);

  logic [6:0]          OPCODE;
  logic [2:0]          FUNC3;
  logic [NUM_INT-1:0]  INTR;
  logic                MIE;
  logic                MEM_ACK;
  logic                PC_WE;
  logic                RF_WE;
  logic                MEM_RDEN1;
  logic                MEM_RDEN2;
  logic                MEM_WE2;
  logic                CSR_WE;
  logic                MRET;
  logic                INT_TAKEN;
  logic [INT_ID_W-1:0] INT_ID;
  logic                ILLEGAL;
  logic                RST_OUT;

  modport master (
    input  OPCODE, FUNC3, INTR, MIE, MEM_ACK,
    output PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
    output MRET, INT_TAKEN, INT_ID, ILLEGAL, RST_OUT
  );

  modport slave (
    output OPCODE, FUNC3, INTR, MIE, MEM_ACK,
    input  PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
    input  MRET, INT_TAKEN, INT_ID, ILLEGAL, RST_OUT
  );
endinterface

// File: rtl/cu_fsm_mc_int_pend_prio.sv
// Sticky interrupt pending bits with a lowest-index-wins priority encoder.
// A clr pulse drops the bit at idx, but a request still held high that cycle re-sets it.
module int_pend_prio #(
  parameter int NUM_INT = 4,
  parameter int IDX_W   = $clog2(NUM_INT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] intr,
  input  logic               clr,
  output logic               any_pend,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_INT-1:0] pend_q, pend_d;
  logic [NUM_INT-1:0] clr_vec;

  always_comb begin
    idx = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pend_q[i]) idx = IDX_W'(i);
    end
    any_pend = |pend_q;
    clr_vec  = clr ? (NUM_INT'(1) << idx) : '0;
    pend_d   = (pend_q & ~clr_vec) | intr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/cu_fsm_mc.sv
// Otter RV32I multicycle control FSM: fetch/exec/writeback/interrupt entry with MEM_ACK-paced memory waits.
// Outputs decode combinationally from state; CU_MEM_TIMEOUT_EN adds a bounded wait that traps with INT_ID=NUM_INT.
module cu_fsm_mc
  import cu_pkg::*;
#(
  parameter int NUM_INT     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  cu_fsm_mc_if.master bus
);

  localparam int INT_ID_W = $clog2(NUM_INT + 1);

  cu_state_t state_q, state_d;
  logic      trap_q, trap_d;
  logic      done;
  logic      timeout;
  logic      any_pend;
  logic      pend_clr;
  logic [INT_ID_W-1:0] pend_idx;

  int_pend_prio #(.NUM_INT(NUM_INT), .IDX_W(INT_ID_W)) u_pend (
    .clk      (CLK),
    .rst      (RST),
    .intr     (bus.INTR),
    .clr      (pend_clr),
    .any_pend (any_pend),
    .idx      (pend_idx)
  );

`ifdef CU_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  always_comb begin
    waiting = (state_q == ST_FETCH) || (state_q == ST_WB) ||
              ((state_q == ST_EXEC) && (bus.OPCODE == OP_STORE));
    // cnt_q counts earlier wait cycles, so the MEM_TIMEOUT-th one aborts.
    timeout = waiting && !bus.MEM_ACK && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    cnt_d = '0;
    if (waiting && !bus.MEM_ACK && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end
`else
  // Waits are unbounded; comparison folds to 0 for any legal MEM_TIMEOUT.
  assign timeout = (MEM_TIMEOUT < 0);
`endif

  always_comb begin
    state_d       = state_q;
    trap_d        = trap_q;
    done          = 1'b0;
    pend_clr      = 1'b0;
    bus.PC_WE     = 1'b0;
    bus.RF_WE     = 1'b0;
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_RDEN2 = 1'b0;
    bus.MEM_WE2   = 1'b0;
    bus.CSR_WE    = 1'b0;
    bus.MRET      = 1'b0;
    bus.INT_TAKEN = 1'b0;
    bus.INT_ID    = '0;
    bus.ILLEGAL   = 1'b0;
    bus.RST_OUT   = 1'b0;

    case (state_q)
      ST_INIT: begin
        bus.RST_OUT = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        bus.MEM_RDEN1 = 1'b1;
        if (bus.MEM_ACK) state_d = ST_EXEC;
        else if (timeout) begin state_d = ST_INTR; trap_d = 1'b1; end
      end
      ST_EXEC: begin
        case (bus.OPCODE)
          OP_LOAD: begin
            bus.MEM_RDEN2 = 1'b1;
            state_d       = ST_WB;
          end
          OP_STORE: begin
            bus.MEM_WE2 = 1'b1;
            if (bus.MEM_ACK) begin bus.PC_WE = 1'b1; done = 1'b1; end
            else if (timeout) begin state_d = ST_INTR; trap_d = 1'b1; end
          end
          OP_BRANCH: begin bus.PC_WE = 1'b1; done = 1'b1; end
          OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            bus.PC_WE = 1'b1; bus.RF_WE = 1'b1; done = 1'b1;
          end
          OP_SYS: begin
            bus.PC_WE = 1'b1;
            done      = 1'b1;
            if (bus.FUNC3 == FUNC3_CSRRW) begin
              bus.RF_WE = 1'b1; bus.CSR_WE = 1'b1;
            end else if (bus.FUNC3 == FUNC3_MRET) bus.MRET = 1'b1;
            else bus.ILLEGAL = 1'b1;
          end
          default: begin bus.PC_WE = 1'b1; bus.ILLEGAL = 1'b1; done = 1'b1; end
        endcase
      end
      ST_WB: begin
        bus.MEM_RDEN2 = 1'b1;
        if (bus.MEM_ACK) begin
          bus.RF_WE = 1'b1; bus.PC_WE = 1'b1; done = 1'b1;
        end else if (timeout) begin state_d = ST_INTR; trap_d = 1'b1; end
      end
      ST_INTR: begin
        bus.INT_TAKEN = 1'b1;
        bus.PC_WE     = 1'b1;
        bus.INT_ID    = trap_q ? INT_ID_W'(NUM_INT) : pend_idx;
        pend_clr      = !trap_q;
        trap_d        = 1'b0;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase

    // Interrupts are only taken at instruction boundaries.
    if (done) state_d = (bus.MIE && any_pend) ? ST_INTR : ST_FETCH;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_INIT;
      trap_q  <= 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
`ifdef CU_MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/cu_fsm_mc.md
Name: cu_fsm_mc

Overview:
- Parametrised multicycle control FSM for the Otter RV32I core.
- Sequences fetch, execute, writeback and interrupt entry. Drives the register-enable strobes (PC, register file, memory, CSR).
- Adds a variable-latency memory handshake and a multi-source prioritised interrupt front end with sticky pending bits.
- Sits beside the combinational decoder. Its INT_TAKEN output feeds that decoder's PC-source override.

Parameters:
- NUM_INT, default 4: number of external interrupt sources (1..16).
- MEM_TIMEOUT, default 15: cycles a memory access may wait for MEM_ACK before abort. Used only with the optional feature.
- INT_ID_W, default $clog2(NUM_INT+1): width of INT_ID. Derived; not overridden.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- OPCODE  in  7  instruction bits [6:0].
- FUNC3  in  3  instruction bits [14:12].
- INTR  in  NUM_INT  level interrupt requests, bit 0 highest priority.
- MIE  in  1  global interrupt enable from the CSR file.
- MEM_ACK  in  1  memory completes the current read or write this cycle.
- PC_WE  out  1  PC register write enable.
- RF_WE  out  1  register file write enable.
- MEM_RDEN1  out  1  instruction read enable.
- MEM_RDEN2  out  1  data read enable.
- MEM_WE2  out  1  data write enable.
- CSR_WE  out  1  CSR write enable.
- MRET  out  1  one-cycle pulse on mret execute.
- INT_TAKEN  out  1  interrupt or trap entry cycle.
- INT_ID  out  INT_ID_W  serviced source index; value NUM_INT = bus-error trap.
- ILLEGAL  out  1  one-cycle pulse on an unrecognised opcode.
- RST_OUT  out  1  PC reset, asserted in ST_INIT.

Behaviour:
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR.
- Async RST forces ST_INIT and clears the pending register and timeout counter. All outputs are 0 during reset except RST_OUT=1.
- Outputs are decoded combinationally from state and inputs. Every output not explicitly driven is 0.
- ST_INIT: RST_OUT=1 for exactly 1 cycle, then ST_FETCH.
- ST_FETCH: MEM_RDEN1=1 and held until MEM_ACK=1, then ST_EXEC. Minimum fetch latency is 1 cycle.
- ST_EXEC, decoded on OPCODE:
  - 0110011, 0010011, 0110111, 0010111, 1101111, 1100111: PC_WE=1, RF_WE=1.
  - 1100011 (branch): PC_WE=1.
  - 0000011 (load): MEM_RDEN2=1 for 1 cycle, next state ST_WB.
  - 0100011 (store): MEM_WE2=1, held in ST_EXEC until MEM_ACK. PC_WE=1 in the MEM_ACK cycle.
  - 1110011, FUNC3=001 (csrrw): PC_WE=1, RF_WE=1, CSR_WE=1.
  - 1110011, FUNC3=000 (mret): PC_WE=1, MRET=1.
  - Any other opcode: PC_WE=1, ILLEGAL=1 (treated as a NOP).
- ST_WB: MEM_RDEN2=1 held until MEM_ACK. In the MEM_ACK cycle: RF_WE=1, PC_WE=1.
- Completion cycle = any cycle with PC_WE=1 in ST_EXEC or ST_WB.
  - If MIE=1 and any pending bit is set, next state is ST_INTR; otherwise ST_FETCH.
- Pending register: pend_next = (pend & ~clr) | INTR. A request still held high in its clear cycle stays pending.
- ST_INTR: INT_TAKEN=1, PC_WE=1, INT_ID = lowest set pending index. That bit's clr=1. Exactly 1 cycle, then ST_FETCH.
- MIE falling while bits are pending: bits are retained, no entry taken.
- Interrupts are never taken mid-instruction or from ST_FETCH.

Optional Feature:
- Macro CU_MEM_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle spent waiting in ST_FETCH, a store ST_EXEC, or ST_WB with MEM_ACK=0. It clears on MEM_ACK or state change.
  - When the counter reaches MEM_TIMEOUT, the access is abandoned: no RF_WE and no PC_WE for the access.
  - Next state is ST_INTR with INT_ID=NUM_INT. No pending bit is cleared. Entry is taken regardless of MIE.
  - MEM_ACK in the same cycle as the timeout wins; the access completes normally.
- Undefined: no counter; waits are unbounded; INT_ID never equals NUM_INT.

Decomposition:
- Package cu_pkg:
  - state enum cu_state_t.
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYS.
  - FUNC3_CSRRW, FUNC3_MRET.
- Sub-module int_pend_prio: pending register plus priority encoder, parametrised by NUM_INT. Outputs any_pend and idx; takes a clr enable.

Test Plan:
- RST high 3 cycles, then released:
  - RST_OUT=1 during reset and for 1 cycle after.
  - Then MEM_RDEN1=1.
  - All other outputs 0.
- Add (0110011), MEM_ACK tied 1:
  - FETCH then EXEC, 2 cycles per instruction.
  - PC_WE=RF_WE=1 in EXEC.
- Load with MEM_ACK delayed 3 cycles in ST_WB:
  - MEM_RDEN2 is held 4 cycles.
  - RF_WE=PC_WE=1 only in the ACK cycle.
- INTR=4'b0110 pulsed for 1 cycle mid-instruction, MIE=1:
  - INT_TAKEN with INT_ID=1 after completion.
  - Next completion gives INT_ID=2.
  - pend=0 afterwards.
- OPCODE=0001111 → ILLEGAL=1 and PC_WE=1 for 1 cycle; FUNC3=000 with 1110011 → MRET=1.
- With CU_MEM_TIMEOUT_EN, MEM_TIMEOUT=15, MEM_ACK held 0 in FETCH:
  - 15 wait cycles, then INT_TAKEN=1 with INT_ID=4.
  - RF_WE never asserted.
